bridge_router: RTL and testbench
================================

Name: bridge_router

Overview:
- Parametrised successor to the fixed bridge address splitter; sits between the APF bridge (clk_74a domain) and N core-side leaves (command, dataslot, ID, ROM, DIP, …).
- Decodes each host access against per-leaf address ranges and forwards registered strobes to exactly one leaf.
- Optionally rebases the address to be leaf-relative.
- Tracks one outstanding read with a valid handshake and a timeout; answers unmapped accesses locally; keeps saturating error counters.

Parameters:
- NUM_LEAVES, 5, number of leaf ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FROM_ADDR, array[NUM_LEAVES] of ADDR_W, default all 0: inclusive range start per leaf.
- TO_ADDR, array[NUM_LEAVES] of ADDR_W, default all 0: inclusive range end per leaf.
- RELATIVE, NUM_LEAVES bits, 0: bit i=1 makes leaf i see addr-FROM_ADDR[i].
- TIMEOUT, 255, cycles allowed in WAIT before error response (range 1..65535).
- UNMAPPED_DATA, DATA_W, 'hFFFF_FFFF: read data returned for unmapped addresses.
- ERR_DATA, DATA_W, 'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk, in, 1: bridge clock (clk_74a).
- reset, in, 1: synchronous, active-high.
- host_addr, in, ADDR_W: access address.
- host_wr, in, 1: write strobe, one-cycle pulse.
- host_wr_data, in, DATA_W: write data.
- host_rd, in, 1: read strobe, one-cycle pulse.
- host_rd_data, out, DATA_W: read result, held until the next completion.
- host_rd_valid, out, 1: one-cycle pulse when host_rd_data is updated.
- host_busy, out, 1: high while a read is outstanding.
- leaf_addr, out, NUM_LEAVES×ADDR_W: per-leaf address (possibly rebased).
- leaf_wr, out, NUM_LEAVES: per-leaf write strobe.
- leaf_wr_data, out, DATA_W: write data, shared by all leaves.
- leaf_rd, out, NUM_LEAVES: per-leaf read strobe.
- leaf_rd_data, in, NUM_LEAVES×DATA_W: per-leaf read data.
- leaf_rd_valid, in, NUM_LEAVES: per-leaf read-data-valid pulse.
- unmapped_count, out, 16: saturating count of unmapped reads and writes.
- timeout_count, out, 16: saturating count of read timeouts.
- overrun_count, out, 16: saturating count of reads dropped while busy.

Behaviour:
- Reset: all outputs 0 (host_rd_data included), state IDLE, counters 0. Reset mid-read aborts it silently: no host_rd_valid, no counter change.
- Decode (combinational):
  - hit[i] = FROM_ADDR[i] <= host_addr <= TO_ADDR[i], unsigned compare.
  - On overlapping ranges the lowest index wins. No hit means unmapped.
- Forwarding (1-cycle latency): on cycle t+1 after a strobe at t, exactly the winning leaf sees leaf_wr/leaf_rd for one cycle.
  - The winning leaf's leaf_addr = host_addr, or host_addr-FROM_ADDR[i] when RELATIVE[i]=1 (ADDR_W modular).
  - leaf_wr_data is a registered copy of host_wr_data.
  - leaf_addr holds its last value when that leaf has no strobe.
- Writes: never block, accepted in any state. Unmapped write is dropped and unmapped_count is incremented.
- State machine, states IDLE and WAIT:
  - IDLE + host_rd, mapped: latch target index, issue leaf_rd at t+1, go to WAIT, host_busy=1 from t+1, timer=0.
  - IDLE + host_rd, unmapped: host_rd_data=UNMAPPED_DATA and host_rd_valid at t+1, unmapped_count++, stay IDLE.
  - WAIT + leaf_rd_valid[target]: capture leaf_rd_data[target]; host_rd_valid next cycle; go to IDLE; host_busy drops with host_rd_valid.
  - WAIT: leaf_rd_valid on any non-target leaf is ignored.
  - WAIT timer reaches TIMEOUT: host_rd_data=ERR_DATA, host_rd_valid, timeout_count++, go to IDLE.
  - Valid in the same cycle as timer expiry: valid wins, no timeout counted.
  - WAIT + host_rd: read dropped (no leaf strobe), overrun_count++.
- Simultaneous host_rd and host_wr: both decode to the same leaf and both are forwarded in the same cycle.
- Counters saturate at 16'hFFFF.

Decomposition:
- bridge_pkg: router_state_e {IDLE, WAIT}, ROUTER_CNT_W=16, default UNMAPPED_DATA/ERR_DATA constants.
- Ranges reuse pocket::bridge_addr_range_t, so FROM/TO can be supplied as a range array.
- Sub-module bridge_range_decode: combinational priority decoder, host_addr → hit one-hot + valid + index, parametrised by NUM_LEAVES/ADDR_W/ranges.

Test Plan:
- Ranges {0–0xFFFFF, 0x200000, 0xF8000000–0xF8001FFF}, RELATIVE=3'b100: write 0xF8000010 data 0x1234 → leaf_wr=3'b100 one cycle later, leaf_addr[2]=0x10, leaf_wr_data=0x1234.
- Read 0x00000040, leaf0 returns 0xCAFEF00D valid 3 cycles after leaf_rd → host_rd_valid 1 cycle after, data 0xCAFEF00D, host_busy high for exactly 4 cycles.
- Read 0x00300000 (unmapped) → host_rd_valid at t+1 with 0xFFFFFFFF, unmapped_count=1; unmapped write → unmapped_count=2, no leaf strobe.
- TIMEOUT=8, leaf never answers → ERR_DATA 0xDEADBEEF, timeout_count=1. Repeat with valid arriving exactly on expiry → leaf data returned, timeout_count unchanged.
- Second host_rd during WAIT → no leaf_rd, overrun_count=1, first read completes normally. Write during WAIT is forwarded.
- Overlapping ranges leaf0/leaf1 both cover 0x100 → only leaf0 strobed. Reset asserted in WAIT → no host_rd_valid, all counters 0, late leaf_rd_valid ignored.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge router: FSM states, counter width,
// default response words and a saturating counter helper.
package bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } router_state_e;

  localparam int ROUTER_CNT_W = 16;

  localparam logic [31:0] DEF_UNMAPPED_DATA = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_ERR_DATA      = 32'hDEAD_BEEF;

  // One leaf's inclusive address window; an array of these maps onto FROM_ADDR/TO_ADDR.
  typedef struct packed {
    logic [31:0] from_addr;
    logic [31:0] to_addr;
  } bridge_addr_range_t;

  function automatic logic [ROUTER_CNT_W-1:0] sat_add(
    input logic [ROUTER_CNT_W-1:0] cnt,
    input logic [1:0]              inc
  );
    logic [ROUTER_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ROUTER_CNT_W-1){1'b0}}, inc};
    return sum[ROUTER_CNT_W] ? '1 : sum[ROUTER_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bridge_range_decode.sv
// Combinational priority decoder: maps an address onto the lowest-indexed leaf
// whose inclusive [FROM_ADDR, TO_ADDR] window contains it.
module bridge_range_decode #(
  parameter int NUM_LEAVES = 5,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 3,
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0] FROM_ADDR = '0,
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0] TO_ADDR   = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_LEAVES-1:0] hit,
  output logic                  valid,
  output logic [IDX_W-1:0]      index
);

  function automatic logic in_span(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] lo,
    input logic [ADDR_W-1:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

  logic [NUM_LEAVES-1:0] in_range;

  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      in_range[i] = in_span(addr, FROM_ADDR[i], TO_ADDR[i]);
    end
  end

  // Scan from the top down so the lowest matching index overwrites the rest.
  always_comb begin
    hit   = '0;
    valid = 1'b0;
    index = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        valid  = 1'b1;
        index  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bridge_router.sv
// Routes APF bridge accesses to N core-side leaves with registered strobes,
// one outstanding read with timeout, local unmapped replies and error counters.
module bridge_router
  import bridge_pkg::*;
#(
  parameter int NUM_LEAVES = 5,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0] FROM_ADDR = '0,
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0] TO_ADDR   = '0,
  parameter logic [NUM_LEAVES-1:0] RELATIVE = '0,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(DEF_UNMAPPED_DATA),
  parameter logic [DATA_W-1:0] ERR_DATA      = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   host_addr,
  input  logic                                host_wr,
  input  logic [DATA_W-1:0]                   host_wr_data,
  input  logic                                host_rd,
  output logic [DATA_W-1:0]                   host_rd_data,
  output logic                                host_rd_valid,
  output logic                                host_busy,
  output logic [NUM_LEAVES-1:0][ADDR_W-1:0]   leaf_addr,
  output logic [NUM_LEAVES-1:0]               leaf_wr,
  output logic [DATA_W-1:0]                   leaf_wr_data,
  output logic [NUM_LEAVES-1:0]               leaf_rd,
  input  logic [NUM_LEAVES-1:0][DATA_W-1:0]   leaf_rd_data,
  input  logic [NUM_LEAVES-1:0]               leaf_rd_valid,
  output logic [ROUTER_CNT_W-1:0]             unmapped_count,
  output logic [ROUTER_CNT_W-1:0]             timeout_count,
  output logic [ROUTER_CNT_W-1:0]             overrun_count
);

  localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [NUM_LEAVES-1:0] hit;
  logic                  hit_valid;
  logic [IDX_W-1:0]      hit_idx;

  bridge_range_decode #(
    .NUM_LEAVES(NUM_LEAVES),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W),
    .FROM_ADDR (FROM_ADDR),
    .TO_ADDR   (TO_ADDR)
  ) u_decode (
    .addr (host_addr),
    .hit  (hit),
    .valid(hit_valid),
    .index(hit_idx)
  );

  router_state_e    state_q, state_d;
  logic [IDX_W-1:0] target_q, target_d;
  logic [15:0]      timer_q, timer_d;
  logic             rd_issue, rd_done;
  logic [DATA_W-1:0] rd_data_d;
  logic             unmapped_rd, unmapped_wr, timeout_hit, overrun_hit;

  assign host_busy   = (state_q == WAIT);
  assign unmapped_wr = host_wr && !hit_valid;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    timer_d     = timer_q;
    rd_issue    = 1'b0;
    rd_done     = 1'b0;
    rd_data_d   = host_rd_data;
    unmapped_rd = 1'b0;
    timeout_hit = 1'b0;
    overrun_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_rd) begin
          if (hit_valid) begin
            rd_issue = 1'b1;
            state_d  = WAIT;
            target_d = hit_idx;
            timer_d  = '0;
          end else begin
            rd_done     = 1'b1;
            rd_data_d   = UNMAPPED_DATA;
            unmapped_rd = 1'b1;
          end
        end
      end
      WAIT: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (leaf_rd_valid[target_q]) begin
          rd_done   = 1'b1;
          rd_data_d = leaf_rd_data[target_q];
          state_d   = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          rd_done     = 1'b1;
          rd_data_d   = ERR_DATA;
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
        overrun_hit = host_rd;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      target_q       <= '0;
      timer_q        <= '0;
      host_rd_data   <= '0;
      host_rd_valid  <= 1'b0;
      leaf_addr      <= '0;
      leaf_wr        <= '0;
      leaf_rd        <= '0;
      leaf_wr_data   <= '0;
      unmapped_count <= '0;
      timeout_count  <= '0;
      overrun_count  <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      timer_q       <= timer_d;
      host_rd_valid <= rd_done;
      if (rd_done) host_rd_data <= rd_data_d;
      leaf_wr       <= host_wr ? hit : '0;
      leaf_rd       <= rd_issue ? hit : '0;
      leaf_wr_data  <= host_wr_data;
      for (int i = 0; i < NUM_LEAVES; i++) begin
        if (hit[i] && (host_wr || rd_issue)) begin
          leaf_addr[i] <= RELATIVE[i] ? (host_addr - FROM_ADDR[i]) : host_addr;
        end
      end
      unmapped_count <= sat_add(unmapped_count, {1'b0, unmapped_rd} + {1'b0, unmapped_wr});
      timeout_count  <= sat_add(timeout_count, {1'b0, timeout_hit});
      overrun_count  <= sat_add(overrun_count, {1'b0, overrun_hit});
    end
  end

endmodule

// File: tb/tb_bridge_router.sv
// Directed bench for bridge_router: write-forwarding vector table plus
// hand-written read, timeout, overrun and reset-abort sequences.
module tb_bridge_router;

  localparam int NL  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  // Leaf 3 sits entirely inside leaf 0 to exercise lowest-index priority.
  localparam logic [NL-1:0][AW-1:0] FROM = {32'h0000_0100, 32'hF800_0000, 32'h0020_0000, 32'h0000_0000};
  localparam logic [NL-1:0][AW-1:0] TO   = {32'h0000_01FF, 32'hF800_1FFF, 32'h0020_0000, 32'h000F_FFFF};

  logic                   clk = 1'b0;
  logic                   reset;
  logic [AW-1:0]          host_addr;
  logic                   host_wr;
  logic [DW-1:0]          host_wr_data;
  logic                   host_rd;
  logic [DW-1:0]          host_rd_data;
  logic                   host_rd_valid;
  logic                   host_busy;
  logic [NL-1:0][AW-1:0]  leaf_addr;
  logic [NL-1:0]          leaf_wr;
  logic [DW-1:0]          leaf_wr_data;
  logic [NL-1:0]          leaf_rd;
  logic [NL-1:0][DW-1:0]  leaf_rd_data;
  logic [NL-1:0]          leaf_rd_valid;
  logic [15:0]            unmapped_count;
  logic [15:0]            timeout_count;
  logic [15:0]            overrun_count;

  always #5 clk = ~clk;

  bridge_router #(
    .NUM_LEAVES(NL),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FROM_ADDR (FROM),
    .TO_ADDR   (TO),
    .RELATIVE  (4'b0100),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_addr     (host_addr),
    .host_wr       (host_wr),
    .host_wr_data  (host_wr_data),
    .host_rd       (host_rd),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .host_busy     (host_busy),
    .leaf_addr     (leaf_addr),
    .leaf_wr       (leaf_wr),
    .leaf_wr_data  (leaf_wr_data),
    .leaf_rd       (leaf_rd),
    .leaf_rd_data  (leaf_rd_data),
    .leaf_rd_valid (leaf_rd_valid),
    .unmapped_count(unmapped_count),
    .timeout_count (timeout_count),
    .overrun_count (overrun_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_unm  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write strobe in one cycle; returns at the negedge of the forwarding cycle.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    host_addr    = addr;
    host_wr      = 1'b1;
    host_wr_data = data;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  // Issue a read; leaf `leaf` answers `delay` cycles after leaf_rd (negative: never).
  task automatic run_read(input logic [31:0] addr, input int leaf, input int delay,
                          input logic [31:0] data, output logic [31:0] got, output int lat,
                          output int busy_cycles, output int rd_pulses, output logic [NL-1:0] first_rd);
    logic got_valid;
    got = '0; lat = 0; busy_cycles = 0; rd_pulses = 0; first_rd = '0; got_valid = 1'b0;
    @(negedge clk);
    host_addr = addr;
    host_rd   = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
    for (int k = 1; k <= 40 && !got_valid; k++) begin
      if (k == 1) first_rd = leaf_rd;
      rd_pulses += $countones(leaf_rd);
      if (host_busy) busy_cycles++;
      if (host_rd_valid) begin
        got_valid = 1'b1;
        got       = host_rd_data;
        lat       = k;
      end
      leaf_rd_valid = '0;
      if (delay >= 0 && k == delay + 1) begin
        leaf_rd_valid[leaf] = 1'b1;
        leaf_rd_data[leaf]  = data;
      end
      @(negedge clk);
    end
    leaf_rd_valid = '0;
  endtask

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [NL-1:0] exp_wr;
    int            exp_leaf;
    logic [31:0]   exp_laddr;
    bit            unm;
  } wr_vec_t;

  wr_vec_t wr_vecs[10];

  logic [31:0]   r_data;
  int            r_lat, r_busy, r_pulses;
  logic [NL-1:0] r_first;

  initial begin
    wr_vecs[0] = '{32'hF800_0010, 32'h0000_1234, 4'b0100,  2, 32'h0000_0010, 1'b0};
    wr_vecs[1] = '{32'h0000_0040, 32'h0000_A5A5, 4'b0001,  0, 32'h0000_0040, 1'b0};
    wr_vecs[2] = '{32'h0020_0000, 32'h0BEE_0001, 4'b0010,  1, 32'h0020_0000, 1'b0};
    wr_vecs[3] = '{32'h0000_0100, 32'h0000_0100, 4'b0001,  0, 32'h0000_0100, 1'b0};
    wr_vecs[4] = '{32'h000F_FFFF, 32'hFFFF_0000, 4'b0001,  0, 32'h000F_FFFF, 1'b0};
    wr_vecs[5] = '{32'h0010_0000, 32'h1111_1111, 4'b0000, -1, 32'h0,         1'b1};
    wr_vecs[6] = '{32'hF800_1FFF, 32'h2222_2222, 4'b0100,  2, 32'h0000_1FFF, 1'b0};
    wr_vecs[7] = '{32'hF7FF_FFFF, 32'h3333_3333, 4'b0000, -1, 32'h0,         1'b1};
    wr_vecs[8] = '{32'h001F_FFFF, 32'h4444_4444, 4'b0000, -1, 32'h0,         1'b1};
    wr_vecs[9] = '{32'hF800_0000, 32'h5555_5555, 4'b0100,  2, 32'h0000_0000, 1'b0};

    reset = 1'b1; host_addr = '0; host_wr = 1'b0; host_wr_data = '0; host_rd = 1'b0;
    leaf_rd_data = '0; leaf_rd_valid = '0;
    repeat (3) @(negedge clk);

    check("reset host_rd_valid", 32'(host_rd_valid), 32'h0);
    check("reset host_rd_data", host_rd_data, 32'h0);
    check("reset host_busy", 32'(host_busy), 32'h0);
    check("reset leaf_wr|leaf_rd", 32'({leaf_wr, leaf_rd}), 32'h0);
    check("reset leaf_addr0", leaf_addr[0], 32'h0);
    check("reset counters", 32'(unmapped_count | timeout_count | overrun_count), 32'h0);
    reset = 1'b0;

    // Mapped read, leaf 0 answers 3 cycles after leaf_rd.
    run_read(32'h0000_0040, 0, 3, 32'hCAFE_F00D, r_data, r_lat, r_busy, r_pulses, r_first);
    check("rd0 leaf_rd onehot", 32'(r_first), 32'h1);
    check("rd0 leaf_rd pulses", 32'(r_pulses), 32'd1);
    check("rd0 data", r_data, 32'hCAFE_F00D);
    check("rd0 latency", 32'(r_lat), 32'd5);
    check("rd0 busy cycles", 32'(r_busy), 32'd4);
    check("rd0 leaf_addr0", leaf_addr[0], 32'h40);

    // Unmapped read answers locally one cycle later.
    run_read(32'h0030_0000, 0, -1, 32'h0, r_data, r_lat, r_busy, r_pulses, r_first);
    exp_unm++;
    check("unm rd data", r_data, 32'hFFFF_FFFF);
    check("unm rd latency", 32'(r_lat), 32'd1);
    check("unm rd no strobe", 32'(r_pulses), 32'd0);
    check("unm rd busy", 32'(r_busy), 32'd0);
    check("unm rd count", 32'(unmapped_count), 32'(exp_unm));

    do_write(32'h0030_0000, 32'hABCD_0000);
    exp_unm++;
    check("unm wr leaf_wr", 32'(leaf_wr), 32'h0);
    check("unm wr count", 32'(unmapped_count), 32'(exp_unm));

    foreach (wr_vecs[i]) begin
      do_write(wr_vecs[i].addr, wr_vecs[i].data);
      if (wr_vecs[i].unm) exp_unm++;
      check($sformatf("wrvec%0d leaf_wr", i), 32'(leaf_wr), 32'(wr_vecs[i].exp_wr));
      check($sformatf("wrvec%0d leaf_rd", i), 32'(leaf_rd), 32'h0);
      check($sformatf("wrvec%0d wr_data", i), leaf_wr_data, wr_vecs[i].data);
      check($sformatf("wrvec%0d unmapped", i), 32'(unmapped_count), 32'(exp_unm));
      if (wr_vecs[i].exp_leaf >= 0)
        check($sformatf("wrvec%0d leaf_addr", i), leaf_addr[wr_vecs[i].exp_leaf], wr_vecs[i].exp_laddr);
    end
    @(negedge clk);
    check("wr strobe one cycle", 32'(leaf_wr), 32'h0);
    check("leaf_addr1 held", leaf_addr[1], 32'h0020_0000);
    check("leaf_addr3 never hit", leaf_addr[3], 32'h0);

    // Leaf never answers: error word after TMO cycles in WAIT.
    run_read(32'h0000_0040, 0, -1, 32'h0, r_data, r_lat, r_busy, r_pulses, r_first);
    check("tmo data", r_data, 32'hDEAD_BEEF);
    check("tmo latency", 32'(r_lat), 32'(TMO + 1));
    check("tmo busy cycles", 32'(r_busy), 32'(TMO));
    check("tmo count", 32'(timeout_count), 32'd1);

    // Response lands in the expiry cycle: data wins, no timeout.
    run_read(32'h0000_0040, 0, TMO - 1, 32'h600D_0007, r_data, r_lat, r_busy, r_pulses, r_first);
    check("expiry data", r_data, 32'h600D_0007);
    check("expiry latency", 32'(r_lat), 32'(TMO + 1));
    check("expiry tmo count", 32'(timeout_count), 32'd1);
    repeat (3) @(negedge clk);
    check("rd_data held", host_rd_data, 32'h600D_0007);
    check("rd_valid idle", 32'(host_rd_valid), 32'h0);

    // Overrun: second read during WAIT is dropped, concurrent write forwarded.
    @(negedge clk); host_addr = 32'h0000_0040; host_rd = 1'b1;
    @(negedge clk); host_rd = 1'b0;
    @(negedge clk); host_addr = 32'h0020_0000; host_rd = 1'b1; host_wr = 1'b1; host_wr_data = 32'h77;
    @(negedge clk); host_rd = 1'b0; host_wr = 1'b0;
    check("ovr leaf_wr", 32'(leaf_wr), 32'b0010);
    check("ovr leaf_rd", 32'(leaf_rd), 32'h0);
    check("ovr wr_data", leaf_wr_data, 32'h77);
    check("ovr count", 32'(overrun_count), 32'd1);
    check("ovr busy", 32'(host_busy), 32'h1);
    leaf_rd_valid = 4'b0010; leaf_rd_data[1] = 32'h0000_BAD1;
    @(negedge clk);
    check("non-target valid ignored", 32'(host_rd_valid), 32'h0);
    check("non-target busy", 32'(host_busy), 32'h1);
    leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'h0FED_CBA9;
    @(negedge clk);
    leaf_rd_valid = '0;
    check("ovr first rd valid", 32'(host_rd_valid), 32'h1);
    check("ovr first rd data", host_rd_data, 32'h0FED_CBA9);
    check("ovr busy drop", 32'(host_busy), 32'h0);

    // Simultaneous read and write in IDLE go to the same leaf together.
    @(negedge clk); host_addr = 32'hF800_0030; host_rd = 1'b1; host_wr = 1'b1; host_wr_data = 32'h9;
    @(negedge clk); host_rd = 1'b0; host_wr = 1'b0;
    check("rdwr leaf_wr", 32'(leaf_wr), 32'b0100);
    check("rdwr leaf_rd", 32'(leaf_rd), 32'b0100);
    check("rdwr leaf_addr2", leaf_addr[2], 32'h30);
    leaf_rd_valid = 4'b0100; leaf_rd_data[2] = 32'h1357_9BDF;
    @(negedge clk);
    leaf_rd_valid = '0;
    check("rdwr rd valid", 32'(host_rd_valid), 32'h1);
    check("rdwr rd data", host_rd_data, 32'h1357_9BDF);
    check("rdwr unmapped", 32'(unmapped_count), 32'(exp_unm));

    // Reset during WAIT aborts silently; a late response is ignored.
    @(negedge clk); host_addr = 32'h0000_0040; host_rd = 1'b1;
    @(negedge clk); host_rd = 1'b0;
    check("pre-reset busy", 32'(host_busy), 32'h1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst busy", 32'(host_busy), 32'h0);
    check("rst rd_valid", 32'(host_rd_valid), 32'h0);
    check("rst rd_data", host_rd_data, 32'h0);
    check("rst counters", 32'(unmapped_count | timeout_count | overrun_count), 32'h0);
    leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'h1111_1111;
    @(negedge clk);
    leaf_rd_valid = '0;
    check("late valid ignored", 32'(host_rd_valid), 32'h0);
    check("late rd_data", host_rd_data, 32'h0);
    @(negedge clk);
    check("late valid no pulse", 32'(host_rd_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
